dbg_guv_cmd_seq: RTL and testbench
==================================

# dbg_guv_cmd_seq

Parametrised command sequencer for the debug governor. It accepts 32-bit commands on an AXI-Stream slave and dispatches PAUSE/DROP/INJECT/LOG operations to any of `NUM_CH` governed channels, each with its own beat or cycle budget. It returns one status word per command and pulses a per-channel done flag when a budget expires. It sits between the host command stream and the per-channel `axis_governor` instances, replacing the single-shot control FSM.

## Interface
- `NUM_CH`, default 5: number of governed channels (rdata, wdata, raddr, awaddr, resp); legal range 1..32.
- `CNT_W`, default 16: budget counter width; legal range 1..24.
- `clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `cmd_in_TDATA`, in, 32: command word.
  - [2:0] op: 0 NOP, 1 PAUSE, 2 DROP, 3 INJECT, 4 LOG, 5 ABORT, 6–7 illegal.
  - [7:3] channel index.
  - [8+CNT_W-1:8] count; 0 means unbounded.
  - Remaining bits are ignored.
- `cmd_in_TVALID`, in, 1: command valid.
- `cmd_in_TREADY`, out, 1: sequencer can accept a command.
- `sts_out_TDATA`, out, 16: status word.
  - [1:0] code: 0 OK, 1 BUSY, 2 BAD_CH, 3 BAD_OP.
  - [4:2] op echo.
  - [9:5] channel echo.
  - [15:10] zero.
- `sts_out_TVALID`, out, 1: status valid.
- `sts_out_TREADY`, in, 1: downstream accepts status.
- `ch_beat`, in, NUM_CH: one-cycle pulse per completed handshake on each governed channel.
- `pause_en`, out, NUM_CH: per-channel enable for the governor.
- `drop_en`, out, NUM_CH: per-channel enable for the governor.
- `inject_en`, out, NUM_CH: per-channel enable for the governor.
- `log_en`, out, NUM_CH: per-channel enable for the governor.
- `ch_done`, out, NUM_CH: one-cycle pulse when a bounded operation exhausts its budget.

## Operation
- Top FSM states: IDLE, DECODE, RESP.
  - IDLE: `cmd_in_TREADY`=1. On TVALID&TREADY, latch the command and go to DECODE.
  - DECODE, one cycle: classify the command, apply it to the target channel if the code is OK, and go to RESP.
  - RESP: `sts_out_TVALID`=1 with TDATA stable. On `sts_out_TREADY`, go to IDLE.
- Classification, in priority order:
  - op 6–7 gives BAD_OP.
  - Otherwise, channel ≥ NUM_CH gives BAD_CH. NOP skips this check and always returns OK.
  - Otherwise, op 1–4 on a non-IDLE channel gives BUSY.
  - Otherwise OK.
- A non-OK code leaves all channel state unchanged.
- Per-channel FSM, states IDLE and ACTIVE:
  - An OK op 1–4 loads `mode` and `remaining`=count, moves to ACTIVE, and sets `unbounded`=(count==0).
  - While ACTIVE, exactly one of the four enables is set for that channel, selected by `mode`.
  - PAUSE decrements `remaining` every clock cycle.
  - DROP, INJECT and LOG decrement `remaining` on each `ch_beat` pulse.
  - A bounded channel whose decrement takes `remaining` from 1 to 0 returns to IDLE on that edge and pulses `ch_done` in the following cycle.
  - An unbounded channel stays ACTIVE until ABORT.
  - ABORT on any channel (IDLE or ACTIVE) returns OK and forces the channel to IDLE; `ch_done` is not pulsed.
- Channels run independently; several channels may be ACTIVE at once.
- `ch_beat` pulses on IDLE channels are ignored.
- Counter arithmetic is unsigned CNT_W-bit. A decrement is never applied at 0, so the counter never wraps.

## Timing
- Reset values:
  - `cmd_in_TREADY`=0; it rises at the first clk edge after `rst` falls.
  - All `*_en`, `ch_done`, `sts_out_TVALID` = 0.
  - `sts_out_TDATA`=0.
  - All channels and the top FSM in IDLE.
- Command acceptance at edge T:
  - DECODE is active in cycle T+1.
  - The channel enable and `sts_out_TVALID` are both asserted from T+2.
- Minimum command-to-command spacing is 3 cycles (IDLE, DECODE, RESP with TREADY high).
- `cmd_in_TREADY` is 0 from acceptance until the status handshake completes, so no command is ever dropped.
- Status is held (VALID high, TDATA constant) while TREADY is low. Channel operations proceed during this stall.
- Bounded PAUSE with count N: `pause_en` is high for exactly N cycles, then `ch_done` pulses once.
- Simultaneous events:
  - ABORT applied in the same cycle as the final `ch_beat`: ABORT wins and no `ch_done` is pulsed.
  - A new command for a channel decoded in the same cycle that channel's budget expires: the command returns BUSY, because the state at DECODE is used.
- `rst` asserted mid-operation clears everything immediately, including a pending status. No status word is generated for the interrupted command.

## Structure
- Package `dbg_guv_pkg` holds:
  - the op enum (`op_e`);
  - the status-code enum (`sts_e`);
  - command field offsets (OP_LSB, CH_LSB, CNT_LSB);
  - the status-word layout constants;
  - the channel-index constants CH_RDATA … CH_RESP.
- Sub-module `dbg_guv_ch_ctrl`, one per channel, generated NUM_CH times:
  - inputs: load, abort, mode, count, beat;
  - outputs: four enables, done, busy.
- The top-level block holds only the command/status FSM and the classification logic.

## Test plan
- Reset release: `cmd_in_TREADY` goes 0→1 one cycle after `rst` falls; all enables are 0.
- DROP ch 1, count 3: status 0x0028 (OK, op 2, ch 1). `drop_en[1]` is high from T+2 until the 3rd `ch_beat[1]`, then `ch_done[1]` pulses once.
- PAUSE ch 0, count 5, with `sts_out_TREADY` held low for 10 cycles: status is held stable, `pause_en[0]` is high for exactly 5 cycles, and no new command is accepted until the status handshake.
- Unbounded LOG ch 4, a second LOG to ch 4, then ABORT ch 4:
  - second LOG returns BUSY (0x0091);
  - ABORT returns OK, `log_en[4]` drops, and no `ch_done` is pulsed.
- Errors:
  - op 7 returns BAD_OP (0x001F);
  - INJECT to ch 9 with NUM_CH=5 returns BAD_CH (0x012E);
  - no enable toggles in either case.
- Assert `rst` mid-DROP (count 100, after 40 beats): all outputs clear immediately. After release, DROP ch 1 count 2 completes normally.

Source files
------------

// File: rtl/dbg_guv_pkg.sv
// dbg_guv_pkg: shared types and constants for the debug-governor command sequencer
// Contents: op/status enums, FSM state type, command and status field offsets,
//           governed-channel indices and a status-word packing helper.
package dbg_guv_pkg;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_PAUSE  = 3'd1,
        OP_DROP   = 3'd2,
        OP_INJECT = 3'd3,
        OP_LOG    = 3'd4,
        OP_ABORT  = 3'd5,
        OP_ILL6   = 3'd6,
        OP_ILL7   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        STS_OK     = 2'd0,
        STS_BUSY   = 2'd1,
        STS_BAD_CH = 2'd2,
        STS_BAD_OP = 2'd3
    } sts_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_RESP
    } seq_state_e;

    typedef enum int {
        CH_RDATA  = 0,
        CH_WDATA  = 1,
        CH_RADDR  = 2,
        CH_AWADDR = 3,
        CH_RESP   = 4
    } ch_id_e;

    localparam int OP_LSB  = 0;
    localparam int CH_LSB  = 3;
    localparam int CNT_LSB = 8;

    localparam int STS_W        = 16;
    localparam int STS_CODE_LSB = 0;
    localparam int STS_OP_LSB   = 2;
    localparam int STS_CH_LSB   = 5;

    function automatic logic [STS_W-1:0] sts_word(input sts_e code, input op_e op, input logic [4:0] ch);
        logic [STS_W-1:0] w;
        w = '0;
        w[STS_CODE_LSB +: 2] = code;
        w[STS_OP_LSB +: 3]   = op;
        w[STS_CH_LSB +: 5]   = ch;
        return w;
    endfunction

endpackage

// File: rtl/dbg_guv_cmd_seq_ch.sv
// dbg_guv_ch_ctrl: per-channel operation tracker with beat/cycle budget
// Ports: clk, rst (async, active-high); load/abort/mode/count from the sequencer;
//        beat = channel handshake pulse; four mode enables, done pulse, busy flag.
module dbg_guv_ch_ctrl
    import dbg_guv_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             abort,
    input  op_e              mode,
    input  logic [CNT_W-1:0] count,
    input  logic             beat,
    output logic             pause_en,
    output logic             drop_en,
    output logic             inject_en,
    output logic             log_en,
    output logic             done,
    output logic             busy
);

    logic             active;
    logic             unbounded;
    op_e              mode_q;
    logic [CNT_W-1:0] remaining;
    logic             dec;

    // PAUSE burns budget every cycle; the other modes only on channel beats
    assign dec       = active && !unbounded && remaining != '0 && (mode_q == OP_PAUSE || beat);
    assign busy      = active;
    assign pause_en  = active && mode_q == OP_PAUSE;
    assign drop_en   = active && mode_q == OP_DROP;
    assign inject_en = active && mode_q == OP_INJECT;
    assign log_en    = active && mode_q == OP_LOG;

    // abort beats a same-cycle final decrement, so no done pulse on abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active    <= 1'b0;
            unbounded <= 1'b0;
            mode_q    <= OP_NOP;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                active <= 1'b0;
            end else if (load) begin
                active    <= 1'b1;
                mode_q    <= mode;
                remaining <= count;
                unbounded <= count == '0;
            end else if (dec) begin
                remaining <= remaining - 1'b1;
                if (remaining == CNT_W'(1)) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dbg_guv_cmd_seq.sv
// dbg_guv_cmd_seq: command/status sequencer dispatching governor ops to NUM_CH channels
// Ports: clk, rst (async, active-high); cmd_in AXI-Stream slave (32-bit commands);
//        sts_out AXI-Stream master (16-bit status); ch_beat per-channel beat pulses;
//        pause_en/drop_en/inject_en/log_en per-channel enables; ch_done budget-expiry pulses.
module dbg_guv_cmd_seq
    import dbg_guv_pkg::*;
#(
    parameter int NUM_CH = CH_RESP + 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       cmd_in_TDATA,
    input  logic              cmd_in_TVALID,
    output logic              cmd_in_TREADY,
    output logic [STS_W-1:0]  sts_out_TDATA,
    output logic              sts_out_TVALID,
    input  logic              sts_out_TREADY,
    input  logic [NUM_CH-1:0] ch_beat,
    output logic [NUM_CH-1:0] pause_en,
    output logic [NUM_CH-1:0] drop_en,
    output logic [NUM_CH-1:0] inject_en,
    output logic [NUM_CH-1:0] log_en,
    output logic [NUM_CH-1:0] ch_done
);

    seq_state_e        state;
    logic [31:0]       cmd_q;
    op_e               op;
    logic [4:0]        ch;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       busy_ext;
    logic              chan_op;
    sts_e              code;
    logic              apply;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] abort;

    // busy is widened so out-of-range channel indices read as idle
    always_comb begin
        op       = op_e'(cmd_q[OP_LSB +: 3]);
        ch       = cmd_q[CH_LSB +: 5];
        cnt      = CNT_W'(cmd_q >> CNT_LSB);
        busy_ext = 32'(busy);
        chan_op  = op inside {OP_PAUSE, OP_DROP, OP_INJECT, OP_LOG};
        code     = (op == OP_ILL6 || op == OP_ILL7)               ? STS_BAD_OP :
                   (op != OP_NOP && {27'd0, ch} >= 32'(NUM_CH))   ? STS_BAD_CH :
                   (chan_op && busy_ext[ch])                      ? STS_BUSY   : STS_OK;
        apply    = state == S_DECODE && code == STS_OK;
    end

    // TREADY is registered, so it first rises one edge after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            cmd_q          <= '0;
            cmd_in_TREADY  <= 1'b0;
            sts_out_TVALID <= 1'b0;
            sts_out_TDATA  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_in_TVALID && cmd_in_TREADY) begin
                        cmd_q         <= cmd_in_TDATA;
                        cmd_in_TREADY <= 1'b0;
                        state         <= S_DECODE;
                    end else begin
                        cmd_in_TREADY <= 1'b1;
                    end
                end
                S_DECODE: begin
                    sts_out_TVALID <= 1'b1;
                    sts_out_TDATA  <= sts_word(code, op, ch);
                    state          <= S_RESP;
                end
                S_RESP: begin
                    if (sts_out_TREADY) begin
                        sts_out_TVALID <= 1'b0;
                        cmd_in_TREADY  <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign load[i]  = apply && chan_op && ch == 5'(i);
        assign abort[i] = apply && op == OP_ABORT && ch == 5'(i);
        dbg_guv_ch_ctrl #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .load      (load[i]),
            .abort     (abort[i]),
            .mode      (op),
            .count     (cnt),
            .beat      (ch_beat[i]),
            .pause_en  (pause_en[i]),
            .drop_en   (drop_en[i]),
            .inject_en (inject_en[i]),
            .log_en    (log_en[i]),
            .done      (ch_done[i]),
            .busy      (busy[i])
        );
    end

endmodule

// File: tb/tb_dbg_guv_cmd_seq.sv
// tb_dbg_guv_cmd_seq: directed, table-driven bench for the command sequencer
module tb_dbg_guv_cmd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cmd_in_TDATA = '0;
    logic        cmd_in_TVALID = 1'b0;
    logic        cmd_in_TREADY;
    logic [15:0] sts_out_TDATA;
    logic        sts_out_TVALID;
    logic        sts_out_TREADY = 1'b1;
    logic [4:0]  ch_beat = '0;
    logic [4:0]  pause_en, drop_en, inject_en, log_en, ch_done;

    int checks = 0;
    int errors = 0;
    int done_tot = 0;
    int pause0_cyc = 0;

    always #5 clk = ~clk;

    dbg_guv_cmd_seq #(.NUM_CH(5), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_in_TDATA   (cmd_in_TDATA),
        .cmd_in_TVALID  (cmd_in_TVALID),
        .cmd_in_TREADY  (cmd_in_TREADY),
        .sts_out_TDATA  (sts_out_TDATA),
        .sts_out_TVALID (sts_out_TVALID),
        .sts_out_TREADY (sts_out_TREADY),
        .ch_beat        (ch_beat),
        .pause_en       (pause_en),
        .drop_en        (drop_en),
        .inject_en      (inject_en),
        .log_en         (log_en),
        .ch_done        (ch_done)
    );

    always @(negedge clk) begin
        if (!rst) begin
            done_tot   <= done_tot + $countones(ch_done);
            pause0_cyc <= pause0_cyc + int'(pause_en[0]);
        end
    end

    typedef struct {
        logic [31:0] cmd;
        logic [15:0] sts;
        logic [4:0]  pause;
        logic [4:0]  drop;
        logic [4:0]  inject;
        logic [4:0]  lg;
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    task automatic beat(input logic [4:0] v);
        ch_beat = v;
        @(posedge clk); #1;
        ch_beat = '0;
    endtask

    // sends one command; dbeat is pulsed during the DECODE cycle, stall holds sts TREADY low
    task automatic send(input logic [31:0] w, input int stall, input logic [4:0] dbeat, output logic [15:0] sts);
        int n;
        bit ok;
        sts = '0;
        cmd_in_TDATA   = w;
        cmd_in_TVALID  = 1'b1;
        sts_out_TREADY = (stall == 0);
        n = 0;
        while (!cmd_in_TREADY && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_in_TREADY) begin
            chk("accept_timeout", 32'(cmd_in_TREADY), 1);
            cmd_in_TVALID  = 1'b0;
            sts_out_TREADY = 1'b1;
            return;
        end
        @(posedge clk); #1;
        cmd_in_TVALID = 1'b0;
        ch_beat = dbeat;
        chk("decode_quiet", {sts_out_TVALID, cmd_in_TREADY}, 0);
        @(posedge clk); #1;
        ch_beat = '0;
        chk("sts_latency", 32'(sts_out_TVALID), 1);
        sts = sts_out_TDATA;
        if (stall > 0) begin
            ok = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                if (!sts_out_TVALID || sts_out_TDATA !== sts || cmd_in_TREADY) ok = 1'b0;
            end
            chk("sts_hold", 32'(ok), 1);
            sts_out_TREADY = 1'b1;
        end
        @(posedge clk); #1;
        chk("sts_release", {sts_out_TVALID, cmd_in_TREADY}, 2'b01);
    endtask

    initial begin
        logic [15:0] s;
        int d0, p0;

        tv[0]  = '{32'h0000_0000, 16'h0000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        tv[1]  = '{32'h0000_00F8, 16'h03E0, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        tv[2]  = '{32'h0000_0007, 16'h001F, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        tv[3]  = '{32'h0000_0016, 16'h005B, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        tv[4]  = '{32'h0000_004B, 16'h012E, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        tv[5]  = '{32'h0000_003D, 16'h00F6, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        tv[6]  = '{32'h0000_001D, 16'h0074, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        tv[7]  = '{32'h0000_0013, 16'h004C, 5'b00000, 5'b00000, 5'b00100, 5'b00000};
        tv[8]  = '{32'h0000_0014, 16'h0051, 5'b00000, 5'b00000, 5'b00100, 5'b00000};
        tv[9]  = '{32'h0000_0015, 16'h0054, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        tv[10] = '{32'h0000_0019, 16'h0064, 5'b01000, 5'b00000, 5'b00000, 5'b00000};
        tv[11] = '{32'h0000_001D, 16'h0074, 5'b00000, 5'b00000, 5'b00000, 5'b00000};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {cmd_in_TREADY, sts_out_TVALID, sts_out_TDATA, pause_en, drop_en, inject_en, log_en, ch_done}, 0);
        rst = 1'b0;
        chk("rst_ready_low", 32'(cmd_in_TREADY), 0);
        @(posedge clk); #1;
        chk("rst_ready_rise", 32'(cmd_in_TREADY), 1);

        d0 = done_tot;
        for (int i = 0; i < 12; i++) begin
            send(tv[i].cmd, 0, 5'b0, s);
            chk($sformatf("vec%0d_sts", i), 32'(s), 32'(tv[i].sts));
            chk($sformatf("vec%0d_en", i), {pause_en, drop_en, inject_en, log_en},
                {tv[i].pause, tv[i].drop, tv[i].inject, tv[i].lg});
        end
        chk("table_no_done", done_tot - d0, 0);

        d0 = done_tot;
        send(32'h0000_030A, 0, 5'b0, s);
        chk("drop1_sts", 32'(s), 32'h0028);
        chk("drop1_en", 32'(drop_en), 32'b00010);
        beat(5'b00010);
        beat(5'b00010);
        chk("drop1_en_mid", 32'(drop_en), 32'b00010);
        beat(5'b00010);
        chk("drop1_en_off", 32'(drop_en), 0);
        chk("drop1_done", 32'(ch_done), 32'b00010);
        @(posedge clk); #1;
        chk("drop1_done_once", done_tot - d0, 1);

        d0 = done_tot;
        p0 = pause0_cyc;
        send(32'h0000_0501, 10, 5'b0, s);
        chk("pause0_sts", 32'(s), 32'h0004);
        repeat (2) @(posedge clk);
        #1;
        chk("pause0_cycles", pause0_cyc - p0, 5);
        chk("pause0_done", done_tot - d0, 1);

        d0 = done_tot;
        send(32'h0000_0024, 0, 5'b0, s);
        chk("log4_sts", 32'(s), 32'h0090);
        beat(5'b10000);
        beat(5'b10000);
        beat(5'b10000);
        chk("log4_unbounded", 32'(log_en), 32'b10000);
        send(32'h0000_0024, 0, 5'b0, s);
        chk("log4_busy", 32'(s), 32'h0091);
        send(32'h0000_0025, 0, 5'b0, s);
        chk("log4_abort_sts", 32'(s), 32'h0094);
        chk("log4_abort_en", 32'(log_en), 0);
        chk("log4_no_done", done_tot - d0, 0);

        d0 = done_tot;
        send(32'h0000_0112, 0, 5'b0, s);
        chk("drop2_sts", 32'(s), 32'h0048);
        send(32'h0000_0015, 0, 5'b00100, s);
        chk("abort_race_sts", 32'(s), 32'h0054);
        chk("abort_race_en", 32'(drop_en), 0);
        chk("abort_race_no_done", done_tot - d0, 0);

        d0 = done_tot;
        send(32'h0000_011A, 0, 5'b0, s);
        chk("drop3_sts", 32'(s), 32'h0068);
        send(32'h0000_011A, 0, 5'b01000, s);
        chk("expiry_race_busy", 32'(s), 32'h0069);
        chk("expiry_race_en", 32'(drop_en), 0);
        chk("expiry_race_done", done_tot - d0, 1);

        send(32'h0000_640A, 0, 5'b0, s);
        chk("drop100_sts", 32'(s), 32'h0028);
        for (int i = 0; i < 40; i++) beat(5'b00010);
        chk("drop100_active", 32'(drop_en), 32'b00010);
        rst = 1'b1;
        #1;
        chk("midrst_clear", {cmd_in_TREADY, sts_out_TVALID, sts_out_TDATA, pause_en, drop_en, inject_en, log_en, ch_done}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        d0 = done_tot;
        send(32'h0000_020A, 0, 5'b0, s);
        chk("post_rst_sts", 32'(s), 32'h0028);
        beat(5'b00010);
        chk("post_rst_en", 32'(drop_en), 32'b00010);
        beat(5'b00010);
        chk("post_rst_done", 32'(ch_done), 32'b00010);
        chk("post_rst_en_off", 32'(drop_en), 0);
        @(posedge clk); #1;
        chk("post_rst_done_once", done_tot - d0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
